// File: rtl/temp_sampler_pkg.sv
// Shared types and constants for the temperature sampler: FSM state encoding
// and the raw sensor code format (12-bit signed, 4 fractional bits = 0.0625 degC/LSB).
package temp_sampler_pkg;
    localparam int RAW_W  = 12;
    localparam int FRAC_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        ACCUM,
        EMIT
    } state_t;
endpackage

// File: rtl/sample_tick_gen.sv
// Free-running period counter 0..P-1 (P = CLK_FREQ/SAMPLE_HZ); tick is high
// for the single cycle in which the counter has just wrapped to 0.
module sample_tick_gen #(
    parameter int CLK_FREQ  = 12000000,
    parameter int SAMPLE_HZ = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int P  = CLK_FREQ / SAMPLE_HZ;
    localparam int CW = (P > 1) ? $clog2(P) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(P - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/temp_sampler.sv
// Periodic temperature sampler: requests 2^AVG_LOG2 conversions per tick, averages
// them and emits whole degC (negative clamped to 0). Optional TEMP_SAMPLER_ALARM_EN adds a hysteresis alarm.
module temp_sampler
    import temp_sampler_pkg::*;
#(
    parameter int CLK_FREQ       = 12000000,
    parameter int SAMPLE_HZ      = 1,
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 120000
`ifdef TEMP_SAMPLER_ALARM_EN
    ,
    parameter int ALARM_HI       = 60,
    parameter int ALARM_LO       = 55
`endif
) (
    input  logic             clk,
    input  logic             rst,
    output logic             conv_start,
    input  logic             raw_valid,
    input  logic [RAW_W-1:0] raw_data,
    output logic [7:0]       data_out,
    output logic             valid,
`ifdef TEMP_SAMPLER_ALARM_EN
    output logic             alarm,
`endif
    output logic             sensor_err
);
    localparam int ACC_W = RAW_W + AVG_LOG2;
    localparam int DEG_W = RAW_W - FRAC_W;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    state_t                    state, state_nx;
    logic                      tick;
    logic signed [ACC_W-1:0]   acc;
    logic signed [RAW_W-1:0]   sample;
    logic signed [ACC_W-1:0]   sample_ext;
    logic [CNT_W-1:0]          cnt;
    logic [TMO_W-1:0]          tmo;
    logic                      timeout;
    logic signed [DEG_W-1:0]   deg;
    logic [7:0]                deg_c;
    logic [7:0]                data_q;

    sample_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .SAMPLE_HZ (SAMPLE_HZ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Average and degC conversion collapse into one floor shift; the result
    // always fits the 8-bit signed range of a 12-bit code.
    assign sample_ext = ACC_W'(sample);
    assign deg        = DEG_W'(acc >>> (AVG_LOG2 + FRAC_W));
    assign deg_c      = deg[DEG_W-1] ? 8'd0 : 8'(deg);
    assign timeout    = (tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign data_out   = (state == EMIT) ? deg_c : data_q;

    always_comb begin
        state_nx   = state;
        conv_start = 1'b0;
        valid      = 1'b0;
        sensor_err = 1'b0;
        case (state)
            IDLE:  if (tick) state_nx = START;
            START: begin
                conv_start = 1'b1;
                state_nx   = WAIT;
            end
            WAIT: begin
                if (raw_valid) begin
                    state_nx = ACCUM;
                end else if (timeout) begin
                    sensor_err = 1'b1;
                    state_nx   = IDLE;
                end
            end
            ACCUM: state_nx = (cnt == LAST_CNT) ? EMIT : START;
            EMIT: begin
                valid    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            sample <= '0;
            cnt    <= '0;
            tmo    <= '0;
            data_q <= 8'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (tick) begin
                    acc <= '0;
                    cnt <= '0;
                end
                START: tmo <= '0;
                WAIT: begin
                    if (raw_valid) sample <= raw_data;
                    else           tmo    <= tmo + 1'b1;
                end
                ACCUM: begin
                    acc <= acc + sample_ext;
                    if (cnt != LAST_CNT) cnt <= cnt + 1'b1;
                end
                EMIT: data_q <= deg_c;
                default: ;
            endcase
        end
    end

`ifdef TEMP_SAMPLER_ALARM_EN
    localparam logic [7:0] A_HI = 8'(ALARM_HI);
    localparam logic [7:0] A_LO = 8'(ALARM_LO);

    // Hysteresis: between the thresholds the alarm keeps its previous state.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm <= 1'b0;
        end else if (state == EMIT) begin
            if (deg_c >= A_HI)      alarm <= 1'b1;
            else if (deg_c <= A_LO) alarm <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_temp_sampler.sv
// Scoreboard bench for temp_sampler: a behavioural sensor answers conv_start from a
// sample queue; expected outputs are queued as samples are supplied and checked on valid/sensor_err.
module tb_temp_sampler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        conv_start;
    logic        raw_valid = 1'b0;
    logic [11:0] raw_data = 12'd0;
    logic [7:0]  data_out;
    logic        valid;
    logic        sensor_err;
`ifdef TEMP_SAMPLER_ALARM_EN
    logic        alarm;
`endif

    always #5 clk = ~clk;

    temp_sampler #(
        .CLK_FREQ       (1000),
        .SAMPLE_HZ      (10),
        .AVG_LOG2       (2),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .conv_start (conv_start),
        .raw_valid  (raw_valid),
        .raw_data   (raw_data),
        .data_out   (data_out),
        .valid      (valid),
`ifdef TEMP_SAMPLER_ALARM_EN
        .alarm      (alarm),
`endif
        .sensor_err (sensor_err)
    );

    typedef struct {
        int is_err;
        int data;
        int alarm;
    } exp_t;

    exp_t exp_q[$];
    int   samp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   cs_cnt = 0;
    int   last_cs = 0;
    int   alarm_m = 0;
    int   alarm_exp = 0;
    int   chk_alarm = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 2048) ? v - 4096 : v;
    endfunction

    function automatic int model(input int s0, input int s1, input int s2, input int s3);
        int sum, avg, d;
        sum = sx(s0) + sx(s1) + sx(s2) + sx(s3);
        avg = sum >>> 2;
        d   = avg >>> 4;
        if (d < 0) d = 0;
        return d & 255;
    endfunction

    always @(posedge clk) cyc++;

    // Sensor: answers each conv_start three cycles later with the next queued
    // code; a negative entry means the sensor stays silent.
    initial begin
        int pend;
        int v;
        logic [11:0] pdata;
        pend = 0;
        pdata = 12'd0;
        forever begin
            @(negedge clk);
            raw_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    raw_valid = 1'b1;
                    raw_data  = pdata;
                end
            end
            if (conv_start && samp_q.size() > 0) begin
                v = samp_q.pop_front();
                if (v >= 0) begin
                    pend  = 3;
                    pdata = v[11:0];
                end
            end
        end
    end

    // Output monitor / scoreboard compare.
    initial begin
        forever begin
            @(negedge clk);
            if (conv_start) begin
                cs_cnt++;
                last_cs = cyc;
            end
`ifdef TEMP_SAMPLER_ALARM_EN
            if (chk_alarm != 0) begin
                chk("alarm", int'(alarm), alarm_exp);
                chk_alarm = 0;
            end
`endif
            if (valid || sensor_err) begin
                if (exp_q.size() == 0) begin
                    chk(valid ? "unexp_valid" : "unexp_err", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (sensor_err) begin
                        chk("err_kind", 1, mon_e.is_err);
                        chk("err_gap", cyc - last_cs, 20);
                        chk("err_no_valid", int'(valid), 0);
                    end else begin
                        chk("valid_kind", 0, mon_e.is_err);
                        chk("data_out", int'(data_out), mon_e.data);
                        alarm_exp = mon_e.alarm;
                        chk_alarm = 1;
                    end
                end
            end
        end
    end

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            chk({tag, "_timeout"}, exp_q.size(), 0);
            exp_q.delete();
            samp_q.delete();
        end
    endtask

    task automatic batch(input string tag, input int s0, input int s1, input int s2, input int s3);
        int d, base;
        d = model(s0, s1, s2, s3);
        if (d >= 60) alarm_m = 1;
        else if (d <= 55) alarm_m = 0;
        base = cs_cnt;
        samp_q.push_back(s0);
        samp_q.push_back(s1);
        samp_q.push_back(s2);
        samp_q.push_back(s3);
        exp_q.push_back('{0, d, alarm_m});
        wait_empty(tag);
        chk({tag, "_conv_starts"}, cs_cnt - base, 4);
        @(negedge clk);
        chk({tag, "_hold"}, int'(data_out), d);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk("rst_conv_start", int'(conv_start), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_sensor_err", int'(sensor_err), 0);
        chk("rst_data_out", int'(data_out), 0);
`ifdef TEMP_SAMPLER_ALARM_EN
        chk("rst_alarm", int'(alarm), 0);
`endif
        rst = 1'b0;

        batch("b25",    'h190, 'h190, 'h190, 'h190);
        batch("bfloor", 'h190, 'h198, 'h1A0, 'h1A8);
        batch("bneg",   'hF00, 'hF00, 'hF00, 'hF00);
        batch("bmax",   'h7FF, 'h7FF, 'h7FF, 'h7FF);
        batch("bneg1",  'hFFF, 'hFFF, 'hFFF, 'hFFF);
        batch("bsub1",  'h010, 'h010, 'h00F, 'h00F);
        batch("bmix",   'h640, 'hE00, 'h640, 'h640);

        // Silent sensor: one timeout, then a normal restart on the next tick.
        base = cs_cnt;
        samp_q.push_back(-1);
        exp_q.push_back('{1, 0, alarm_m});
        wait_empty("tmo");
        chk("tmo_conv_starts", cs_cnt - base, 1);
        batch("brestart", 'h190, 'h190, 'h190, 'h190);

        // Reset while waiting on the third sample of a conversion.
        base = cs_cnt;
        for (int i = 0; i < 4; i++) samp_q.push_back('h190);
        for (int i = 0; i < 400 && cs_cnt < base + 3; i++) @(negedge clk);
        chk("rst_mid_reached", cs_cnt - base, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        samp_q.delete();
        alarm_m = 0;
        chk("rstmid_conv_start", int'(conv_start), 0);
        chk("rstmid_valid", int'(valid), 0);
        chk("rstmid_sensor_err", int'(sensor_err), 0);
        chk("rstmid_data_out", int'(data_out), 0);
        batch("bfresh", 'h2A0, 'h2A0, 'h2B0, 'h2B0);

`ifdef TEMP_SAMPLER_ALARM_EN
        batch("al50", 'h320, 'h320, 'h320, 'h320);
        batch("al60", 'h3C0, 'h3C0, 'h3C0, 'h3C0);
        batch("al57", 'h390, 'h390, 'h390, 'h390);
        batch("al55", 'h370, 'h370, 'h370, 'h370);
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/temp_sampler.md
TEMP_SAMPLER -- requirements
Module: temp_sampler

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_HZ, default 1, sample-request rate in Hz; period P = CLK_FREQ/SAMPLE_HZ cycles.
REQ-003 SHALL have parameter AVG_LOG2, default 2, number of raw samples averaged per output, equal to 2^AVG_LOG2 (range 0..4).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 120000, maximum wait for raw_valid after conv_start.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port conv_start, output, 1 bit: one-cycle request to the sensor front-end to start a conversion.
REQ-008 SHALL have port raw_valid, input, 1 bit: one-cycle strobe qualifying raw_data.
REQ-009 SHALL have port raw_data, input, 12 bits: signed two's-complement temperature code, 0.0625 degC/LSB.
REQ-010 SHALL have port data_out, output, 8 bits: averaged temperature in whole degC, unsigned; feeds the UART transmitter data_in.
REQ-011 SHALL have port valid, output, 1 bit: one-cycle strobe qualifying data_out; feeds the UART transmitter valid.
REQ-012 SHALL have port sensor_err, output, 1 bit: one-cycle pulse on conversion timeout.

Function
REQ-013 SHALL implement states IDLE, START, WAIT, ACCUM, EMIT.
REQ-014 SHALL count a free-running period counter 0..P-1 and raise an internal tick when it wraps to 0; the tick SHALL NOT be gated by state.
REQ-015 IDLE: on tick, clear accumulator and sample count, go to START.
REQ-016 START: assert conv_start for exactly one cycle, clear timeout counter, go to WAIT.
REQ-017 WAIT: on raw_valid, capture raw_data and go to ACCUM; raw_valid outside WAIT SHALL be ignored.
REQ-018 WAIT: when the timeout counter reaches TIMEOUT_CYCLES-1 without raw_valid, pulse sensor_err for one cycle, discard partial accumulation, return to IDLE.
REQ-019 ACCUM: sign-extend the sample into a (12+AVG_LOG2)-bit signed accumulator and add it; if the count is below 2^AVG_LOG2-1, increment it and go to START, otherwise go to EMIT.
REQ-020 EMIT: compute avg = accumulator arithmetically shifted right by AVG_LOG2, then deg = avg arithmetically shifted right by 4 (floor); negative deg SHALL clamp to 0; drive data_out = deg[7:0], assert valid for one cycle, return to IDLE.
REQ-021 data_out SHALL hold its value until the next EMIT.
REQ-022 A tick arriving while not in IDLE SHALL be dropped (no queueing, no restart).
REQ-023 Latency: valid SHALL assert exactly one cycle after the ACCUM cycle of the final sample.
REQ-024 Spacing between valid pulses SHALL be at least P cycles; integrators SHALL choose P > 4*10*(CLK_FREQ/9600) so the downstream transmitter is idle.

Reset
REQ-025 On rst: state IDLE, period/timeout/sample counters 0, accumulator 0, conv_start 0, valid 0, sensor_err 0, data_out 8'd0.
REQ-026 rst asserted mid-conversion SHALL abandon the conversion without emitting valid or sensor_err.

Configuration
REQ-027 With macro TEMP_SAMPLER_ALARM_EN defined: add parameter ALARM_HI (default 60) and ALARM_LO (default 55) and output port alarm (1 bit), which sets when an emitted data_out >= ALARM_HI and clears when an emitted data_out <= ALARM_LO, updates only on EMIT, and resets to 0.
REQ-028 Without TEMP_SAMPLER_ALARM_EN: no alarm port, no alarm parameters, no alarm logic.

Structure
REQ-029 A shared package SHALL hold the state encoding, the 0.0625 degC fractional width constant (4), and the raw width constant (12).
REQ-030 The period counter SHALL be a sub-module sample_tick_gen (parameters CLK_FREQ, SAMPLE_HZ; output tick).

Verification
REQ-031 CLK_FREQ=1000, SAMPLE_HZ=10, AVG_LOG2=2; sensor returns 0x190 (25.0 degC) four times -> four conv_start pulses, then data_out=25 with a single valid.
REQ-032 Samples 0x190, 0x198, 0x1A0, 0x1A8 (avg 25.75) -> data_out=25 (floor).
REQ-033 Samples 0xF00 (-16 degC) x4 -> data_out=0, valid=1.
REQ-034 TIMEOUT_CYCLES=20; no raw_valid -> sensor_err pulse 20 cycles after conv_start, no valid, next tick restarts normally.
REQ-035 rst asserted during WAIT of sample 3 -> all outputs 0 next cycle, no valid; the next tick begins a fresh 4-sample average.
REQ-036 TEMP_SAMPLER_ALARM_EN defined; emitted sequence 50, 60, 57, 55 -> alarm 0, 1, 1, 0.
